ysyx_22050243_lsu: RTL and testbench
====================================

Name: ysyx_22050243_lsu

Overview:
Load/store unit sitting directly upstream of the unified memory block on its data port. It accepts one load/store request from the EXU over a valid/ready handshake and checks alignment. It drives the memory data strobes, address, byte-lane write mask and lane-shifted write data, then captures the read data and shifts and extends it. The result is returned to WBU over a valid/ready handshake.

Parameters:
XLEN, 64, width of addresses and data.
LOAD_LATENCY, 1, cycles from the data_r_en strobe to data_r being valid (range 1..7).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  EXU request valid
req_ready  out  1  LSU can accept a request
req_store  in  1  1 = store, 0 = load
req_funct3  in  3  RV64 funct3: LB/SB=000, LH/SH=001, LW/SW=010, LD/SD=011, LBU=100, LHU=101, LWU=110
req_addr  in  XLEN  effective byte address
req_wdata  in  XLEN  store data, right-aligned
req_rd  in  5  destination register tag, passed through
data_r_en  out  1  memory read strobe
data_w_en  out  1  memory write strobe
data_addr  out  XLEN  memory address, equal to the latched req_addr
data_wmask  out  XLEN  bit-granular write mask
data_w  out  XLEN  lane-shifted write data
data_r  in  XLEN  memory read data, 8-byte aligned doubleword
resp_valid  out  1  result valid to WBU
resp_ready  in  1  WBU accepts the result
resp_rdata  out  XLEN  extended load result; 0 for stores
resp_rd  out  5  latched req_rd
resp_is_store  out  1  latched req_store
resp_misalign  out  1  address misaligned for the access size
resp_illegal  out  1  funct3 illegal for the op (store with funct3[2]=1, or load 111)

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE; every output and internal register is 0; no strobe is issued after reset is released.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - req_ready=1; all other outputs 0.
  - On req_valid: latch all req_* fields.
  - Illegal funct3 or misaligned address -> RESP with the matching flag set, no memory strobe.
  - Otherwise -> ACCESS.
- Alignment rules (size = funct3[1:0]):
  - byte: always aligned.
  - half: addr[0]==0.
  - word: addr[1:0]==0.
  - dword: addr[2:0]==0.
  - resp_illegal takes priority; resp_misalign is 0 when resp_illegal=1.
- ACCESS: exactly one cycle; data_addr valid.
  - Store: data_w_en=1; data_wmask = size mask shifted left by addr[2:0]*8 (size mask = 0xFF / 0xFFFF / 0xFFFF_FFFF / all-ones); data_w = req_wdata shifted left by addr[2:0]*8. Next state RESP.
  - Load: data_r_en=1; next state WAIT with counter = LOAD_LATENCY.
- WAIT:
  - Counter decrements each cycle; strobes are 0.
  - In the cycle the counter reaches 1, sample data_r, shift it right by addr[2:0]*8 and truncate to size.
  - Extension: sign-extend when funct3[2]=0, zero-extend when funct3[2]=1.
  - Store the result in resp_rdata, then go to RESP.
- RESP:
  - resp_* registered and stable while resp_valid=1 and resp_ready=0; req_ready=0.
  - On resp_ready: -> IDLE and resp_valid drops the next cycle.
- Timing and throughput:
  - Minimum store request-to-resp_valid latency is 2 cycles; load latency is 2+LOAD_LATENCY.
  - Requests are never overlapped; the next acceptance is the cycle after the response handshake.
- Strobe rules: data_r_en and data_w_en are never both high, and each is high for exactly one cycle per legal request.
- Response content rules: resp_rdata=0 for stores and for faulted requests.
- resp_rd always echoes the latched req_rd, including on faults.

Decomposition:
- Shared package ysyx_22050243_pkg holds:
  - funct3 encodings (LB..LWU, SB..SD).
  - FSM state encoding.
  - Size-mask constants.
- One natural sub-module, ysyx_22050243_lsu_align: purely combinational (funct3, addr[2:0], wdata, rdata) -> (wmask, wdata_sh, rdata_ext, misalign, illegal). It is reused by the bench reference model.

Test Plan:
- SD addr=0x8000_0008, wdata=0x1122334455667788 -> one-cycle data_w_en; wmask=all-ones; data_w=0x1122334455667788; resp_valid 2 cycles after acceptance with resp_is_store=1.
- SB addr=0x8000_0003, wdata=0x...AB -> wmask=0x0000_0000_FF00_0000, data_w[31:24]=0xAB; no data_r_en.
- LB addr=0x8000_0005 with data_r=0x0000_8000_0000_0000 -> resp_rdata=0xFFFF_FFFF_FFFF_FF80. The same access with LBU -> 0x80. Also repeat with LOAD_LATENCY=3 to check timing.
- LW addr=0x8000_0002 -> resp_misalign=1, no strobe in any cycle. Load with funct3=111 -> resp_illegal=1, resp_misalign=0.
- Backpressure: resp_ready=0 for 3 cycles during a load -> resp_valid and resp_rdata stable, req_ready=0, no new strobe; accepted on the 4th cycle.
- Reset mid-operation: assert rst_n=0 during WAIT -> all outputs 0 immediately, FSM in IDLE. After release, an SD request completes correctly and no stale data is returned.

Source files
------------

// File: rtl/ysyx_22050243_lsu_pkg.sv
// rtl/ysyx_22050243_lsu_pkg.sv - shared funct3 encodings, FSM states and size masks for the LSU
package ysyx_22050243_pkg;

  localparam logic [2:0] F3_LB   = 3'b000;
  localparam logic [2:0] F3_LH   = 3'b001;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_LD   = 3'b011;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_LHU  = 3'b101;
  localparam logic [2:0] F3_LWU  = 3'b110;
  localparam logic [2:0] F3_LILL = 3'b111;
  localparam logic [2:0] F3_SB   = 3'b000;
  localparam logic [2:0] F3_SH   = 3'b001;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_SD   = 3'b011;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [63:0] MASK_B = 64'h0000_0000_0000_00FF;
  localparam logic [63:0] MASK_H = 64'h0000_0000_0000_FFFF;
  localparam logic [63:0] MASK_W = 64'h0000_0000_FFFF_FFFF;
  localparam logic [63:0] MASK_D = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_e;

  // Byte-lane mask of an access of the given size, right-aligned.
  function automatic logic [63:0] size_mask(input logic [1:0] sz);
    case (sz)
      SZ_B:    size_mask = MASK_B;
      SZ_H:    size_mask = MASK_H;
      SZ_W:    size_mask = MASK_W;
      default: size_mask = MASK_D;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22050243_lsu_if.sv
// rtl/ysyx_22050243_lsu_if.sv - EXU request, memory data port and WBU response bundle of the LSU
interface ysyx_22050243_lsu_if #(
  parameter int XLEN = 64
);
  logic            req_valid;
  logic            req_ready;
  logic            req_store;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [4:0]      req_rd;

  logic            data_r_en;
  logic            data_w_en;
  logic [XLEN-1:0] data_addr;
  logic [XLEN-1:0] data_wmask;
  logic [XLEN-1:0] data_w;
  logic [XLEN-1:0] data_r;

  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic [4:0]      resp_rd;
  logic            resp_is_store;
  logic            resp_misalign;
  logic            resp_illegal;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
    output req_ready,
    output data_r_en, data_w_en, data_addr, data_wmask, data_w,
    input  data_r,
    output resp_valid, resp_rdata, resp_rd, resp_is_store, resp_misalign, resp_illegal,
    input  resp_ready
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
    input  req_ready,
    input  data_r_en, data_w_en, data_addr, data_wmask, data_w,
    output data_r,
    input  resp_valid, resp_rdata, resp_rd, resp_is_store, resp_misalign, resp_illegal,
    output resp_ready
  );
endinterface

// File: rtl/ysyx_22050243_lsu_align.sv
// rtl/ysyx_22050243_lsu_align.sv - combinational lane shifting, extension and alignment checks
module ysyx_22050243_lsu_align
  import ysyx_22050243_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            store,
  input  logic [2:0]      funct3,
  input  logic [2:0]      addr_lo,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] wmask,
  output logic [XLEN-1:0] wdata_sh,
  output logic [XLEN-1:0] rdata_ext,
  output logic            misalign,
  output logic            illegal
);

  logic [1:0]      sz;
  logic [5:0]      shamt;
  logic [XLEN-1:0] rsh;
  logic            sx;

  // Size decode, fault flags, store lane placement and load extraction.
  always_comb begin
    sz    = funct3[1:0];
    shamt = {addr_lo, 3'b000};
    sx    = ~funct3[2];

    // Stores have no unsigned forms; loads only lack the 111 encoding.
    illegal = store ? funct3[2] : (funct3 == F3_LILL);

    case (sz)
      SZ_B:    misalign = 1'b0;
      SZ_H:    misalign = addr_lo[0];
      SZ_W:    misalign = |addr_lo[1:0];
      default: misalign = |addr_lo;
    endcase
    if (illegal) misalign = 1'b0;

    wmask    = XLEN'(size_mask(sz)) << shamt;
    wdata_sh = wdata << shamt;

    rsh = rdata >> shamt;
    case (sz)
      SZ_B:    rdata_ext = {{(XLEN-8){sx & rsh[7]}}, rsh[7:0]};
      SZ_H:    rdata_ext = {{(XLEN-16){sx & rsh[15]}}, rsh[15:0]};
      SZ_W:    rdata_ext = {{(XLEN-32){sx & rsh[31]}}, rsh[31:0]};
      default: rdata_ext = rsh;
    endcase
  end

endmodule

// File: rtl/ysyx_22050243_lsu.sv
// rtl/ysyx_22050243_lsu.sv - load/store unit between EXU/WBU handshakes and the memory data port
module ysyx_22050243_lsu
  import ysyx_22050243_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int LOAD_LATENCY = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  ysyx_22050243_lsu_if.slave   bus
);

  lsu_state_e      state;
  logic            st_q;
  logic [2:0]      f3_q;
  logic [2:0]      lo_q;
  logic [4:0]      rd_q;
  logic [2:0]      cnt;

  logic            idle;
  logic            a_store;
  logic [2:0]      a_f3;
  logic [2:0]      a_lo;
  logic [XLEN-1:0] a_wmask;
  logic [XLEN-1:0] a_wdata_sh;
  logic [XLEN-1:0] a_rdata_ext;
  logic            a_mis;
  logic            a_ill;

  // In IDLE the checker looks at the incoming request, afterwards at the latched one.
  always_comb begin
    idle    = (state == ST_IDLE);
    a_store = idle ? bus.req_store         : st_q;
    a_f3    = idle ? bus.req_funct3        : f3_q;
    a_lo    = idle ? bus.req_addr[2:0]     : lo_q;
  end

  ysyx_22050243_lsu_align #(.XLEN(XLEN)) u_align (
    .store     (a_store),
    .funct3    (a_f3),
    .addr_lo   (a_lo),
    .wdata     (bus.req_wdata),
    .rdata     (bus.data_r),
    .wmask     (a_wmask),
    .wdata_sh  (a_wdata_sh),
    .rdata_ext (a_rdata_ext),
    .misalign  (a_mis),
    .illegal   (a_ill)
  );

  // Request/response FSM; every output is a register so strobes are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      st_q              <= 1'b0;
      f3_q              <= 3'd0;
      lo_q              <= 3'd0;
      rd_q              <= 5'd0;
      cnt               <= 3'd0;
      bus.req_ready     <= 1'b0;
      bus.data_r_en     <= 1'b0;
      bus.data_w_en     <= 1'b0;
      bus.data_addr     <= '0;
      bus.data_wmask    <= '0;
      bus.data_w        <= '0;
      bus.resp_valid    <= 1'b0;
      bus.resp_rdata    <= '0;
      bus.resp_rd       <= 5'd0;
      bus.resp_is_store <= 1'b0;
      bus.resp_misalign <= 1'b0;
      bus.resp_illegal  <= 1'b0;
    end else begin
      bus.data_r_en <= 1'b0;
      bus.data_w_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          bus.req_ready <= 1'b1;
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            st_q          <= bus.req_store;
            f3_q          <= bus.req_funct3;
            lo_q          <= bus.req_addr[2:0];
            rd_q          <= bus.req_rd;
            if (a_ill || a_mis) begin
              // Faulted requests never touch memory.
              state             <= ST_RESP;
              bus.resp_valid    <= 1'b1;
              bus.resp_rdata    <= '0;
              bus.resp_rd       <= bus.req_rd;
              bus.resp_is_store <= bus.req_store;
              bus.resp_illegal  <= a_ill;
              bus.resp_misalign <= a_mis;
            end else begin
              state         <= ST_ACCESS;
              bus.data_addr <= bus.req_addr;
              if (bus.req_store) begin
                bus.data_w_en  <= 1'b1;
                bus.data_wmask <= a_wmask;
                bus.data_w     <= a_wdata_sh;
              end else begin
                bus.data_r_en  <= 1'b1;
              end
            end
          end
        end
        ST_ACCESS: begin
          bus.data_addr  <= '0;
          bus.data_wmask <= '0;
          bus.data_w     <= '0;
          if (st_q) begin
            state             <= ST_RESP;
            bus.resp_valid    <= 1'b1;
            bus.resp_rdata    <= '0;
            bus.resp_rd       <= rd_q;
            bus.resp_is_store <= 1'b1;
          end else begin
            state <= ST_WAIT;
            cnt   <= 3'(LOAD_LATENCY);
          end
        end
        ST_WAIT: begin
          if (cnt == 3'd1) begin
            state             <= ST_RESP;
            cnt               <= 3'd0;
            bus.resp_valid    <= 1'b1;
            bus.resp_rdata    <= a_rdata_ext;
            bus.resp_rd       <= rd_q;
            bus.resp_is_store <= 1'b0;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            state             <= ST_IDLE;
            bus.req_ready     <= 1'b1;
            bus.resp_valid    <= 1'b0;
            bus.resp_rdata    <= '0;
            bus.resp_rd       <= 5'd0;
            bus.resp_is_store <= 1'b0;
            bus.resp_misalign <= 1'b0;
            bus.resp_illegal  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050243_lsu.sv
// tb/tb_ysyx_22050243_lsu.sv - directed self-checking bench for the LSU
module tb_ysyx_22050243_lsu;

  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ysyx_22050243_lsu_if #(.XLEN(64)) bus1 ();
  ysyx_22050243_lsu_if #(.XLEN(64)) bus3 ();

  ysyx_22050243_lsu #(.XLEN(64), .LOAD_LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  ysyx_22050243_lsu #(.XLEN(64), .LOAD_LATENCY(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  logic        t_sel = 1'b0;
  logic        t_valid = 1'b0;
  logic        t_store = 1'b0;
  logic [2:0]  t_f3 = 3'd0;
  logic [63:0] t_addr = '0;
  logic [63:0] t_wdata = '0;
  logic [4:0]  t_rd = 5'd0;
  logic        t_ready = 1'b0;
  logic [63:0] rd_val = '0;

  assign bus1.req_valid  = t_valid & ~t_sel;
  assign bus3.req_valid  = t_valid &  t_sel;
  assign bus1.resp_ready = t_ready & ~t_sel;
  assign bus3.resp_ready = t_ready &  t_sel;
  assign bus1.req_store  = t_store;
  assign bus3.req_store  = t_store;
  assign bus1.req_funct3 = t_f3;
  assign bus3.req_funct3 = t_f3;
  assign bus1.req_addr   = t_addr;
  assign bus3.req_addr   = t_addr;
  assign bus1.req_wdata  = t_wdata;
  assign bus3.req_wdata  = t_wdata;
  assign bus1.req_rd     = t_rd;
  assign bus3.req_rd     = t_rd;

  // Memory model: read data is valid only LOAD_LATENCY cycles after the strobe.
  logic [7:0] pipe1 = '0;
  logic [7:0] pipe3 = '0;
  always @(posedge clk) begin
    pipe1 <= {pipe1[6:0], bus1.data_r_en};
    pipe3 <= {pipe3[6:0], bus3.data_r_en};
  end
  assign bus1.data_r = pipe1[0] ? rd_val : JUNK;
  assign bus3.data_r = pipe3[2] ? rd_val : JUNK;

  logic        o_req_ready, o_ren, o_wen, o_resp_valid, o_st, o_mis, o_ill;
  logic [63:0] o_addr, o_wmask, o_w, o_rdata;
  logic [4:0]  o_rd;
  assign o_req_ready  = t_sel ? bus3.req_ready     : bus1.req_ready;
  assign o_ren        = t_sel ? bus3.data_r_en     : bus1.data_r_en;
  assign o_wen        = t_sel ? bus3.data_w_en     : bus1.data_w_en;
  assign o_addr       = t_sel ? bus3.data_addr     : bus1.data_addr;
  assign o_wmask      = t_sel ? bus3.data_wmask    : bus1.data_wmask;
  assign o_w          = t_sel ? bus3.data_w        : bus1.data_w;
  assign o_resp_valid = t_sel ? bus3.resp_valid    : bus1.resp_valid;
  assign o_rdata      = t_sel ? bus3.resp_rdata    : bus1.resp_rdata;
  assign o_rd         = t_sel ? bus3.resp_rd       : bus1.resp_rd;
  assign o_st         = t_sel ? bus3.resp_is_store : bus1.resp_is_store;
  assign o_mis        = t_sel ? bus3.resp_misalign : bus1.resp_misalign;
  assign o_ill        = t_sel ? bus3.resp_illegal  : bus1.resp_illegal;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int          lat, n_wen, n_ren;
  logic [63:0] c_wmask, c_w, c_addr, c_rdata;
  logic [4:0]  c_rd;
  logic        c_st, c_mis, c_ill;

  // One request/response; bp extra cycles of resp_ready=0 after resp_valid is first seen.
  task automatic txn(input logic sel, input logic st, input logic [2:0] f3,
                     input logic [63:0] addr, input logic [63:0] wd,
                     input logic [4:0] rd, input int bp);
    int n;
    t_sel = sel;
    #1;
    n = 0;
    while (!o_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", 64'(o_req_ready), 64'd1);
    t_store = st; t_f3 = f3; t_addr = addr; t_wdata = wd; t_rd = rd;
    t_valid = 1'b1; t_ready = 1'b0;
    @(posedge clk);
    #1 t_valid = 1'b0;
    lat = 0; n_wen = 0; n_ren = 0; c_wmask = '0; c_w = '0; c_addr = '0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (o_wen) begin n_wen++; c_wmask = o_wmask; c_w = o_w; c_addr = o_addr; end
      if (o_ren) begin n_ren++; c_addr = o_addr; end
      if (o_resp_valid) break;
    end
    check("resp_valid_seen", 64'(o_resp_valid), 64'd1);
    c_rdata = o_rdata; c_rd = o_rd; c_st = o_st; c_mis = o_mis; c_ill = o_ill;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(o_resp_valid), 64'd1);
      check("bp_rdata", o_rdata, c_rdata);
      check("bp_req_ready", 64'(o_req_ready), 64'd0);
      check("bp_strobe", 64'({o_ren, o_wen}), 64'd0);
    end
    t_ready = 1'b1;
    @(posedge clk);
    #1 t_ready = 1'b0;
    @(negedge clk);
    check("post_valid", 64'(o_resp_valid), 64'd0);
    check("post_ready", 64'(o_req_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(bus1.req_ready), 64'd0);
    check("rst_strobes", 64'({bus1.data_r_en, bus1.data_w_en}), 64'd0);
    check("rst_addr", bus1.data_addr | bus1.data_wmask | bus1.data_w, 64'd0);
    check("rst_resp", 64'({bus1.resp_valid, bus1.resp_rd, bus1.resp_is_store,
                           bus1.resp_misalign, bus1.resp_illegal}), 64'd0);
    check("rst_rdata", bus1.resp_rdata, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 64'(bus1.req_ready), 64'd1);

    // SD aligned
    txn(0, 1, 3'b011, 64'h8000_0008, 64'h1122_3344_5566_7788, 5'd5, 0);
    check("sd_lat", lat, 2);
    check("sd_wen", n_wen, 1);
    check("sd_ren", n_ren, 0);
    check("sd_wmask", c_wmask, 64'hFFFF_FFFF_FFFF_FFFF);
    check("sd_w", c_w, 64'h1122_3344_5566_7788);
    check("sd_addr", c_addr, 64'h8000_0008);
    check("sd_flags", 64'({c_st, c_mis, c_ill}), 64'b100);
    check("sd_rd", 64'(c_rd), 64'd5);
    check("sd_rdata", c_rdata, 64'd0);

    // SB byte 3
    txn(0, 1, 3'b000, 64'h8000_0003, 64'hCAFE_0000_0000_00AB, 5'd6, 0);
    check("sb_wmask", c_wmask, 64'h0000_0000_FF00_0000);
    check("sb_w", c_w, 64'h0000_0000_AB00_0000);
    check("sb_ren", n_ren, 0);
    check("sb_wen", n_wen, 1);

    // SW upper word, SH lane 2
    txn(0, 1, 3'b010, 64'h8000_0004, 64'h0000_0000_DEAD_BEEF, 5'd7, 0);
    check("sw_wmask", c_wmask, 64'hFFFF_FFFF_0000_0000);
    check("sw_w", c_w, 64'hDEAD_BEEF_0000_0000);
    txn(0, 1, 3'b001, 64'h8000_0002, 64'h0000_0000_0000_1234, 5'd8, 0);
    check("sh_wmask", c_wmask, 64'h0000_0000_FFFF_0000);
    check("sh_w", c_w, 64'h0000_0000_1234_0000);

    // LB / LBU byte 5
    rd_val = 64'h0000_8000_0000_0000;
    txn(0, 0, 3'b000, 64'h8000_0005, 64'd0, 5'd9, 0);
    check("lb_lat", lat, 3);
    check("lb_ren", n_ren, 1);
    check("lb_wen", n_wen, 0);
    check("lb_addr", c_addr, 64'h8000_0005);
    check("lb_rdata", c_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    check("lb_flags", 64'({c_st, c_mis, c_ill}), 64'b000);
    check("lb_rd", 64'(c_rd), 64'd9);
    txn(0, 0, 3'b100, 64'h8000_0005, 64'd0, 5'd10, 0);
    check("lbu_rdata", c_rdata, 64'h0000_0000_0000_0080);

    // Halfword / word / dword extraction, with backpressure on LH
    rd_val = 64'h8001_2345_6789_ABCD;
    txn(0, 0, 3'b001, 64'h8000_0006, 64'd0, 5'd11, 2);
    check("lh_rdata", c_rdata, 64'hFFFF_FFFF_FFFF_8001);
    check("lh_ren", n_ren, 1);
    txn(0, 0, 3'b101, 64'h8000_0006, 64'd0, 5'd11, 0);
    check("lhu_rdata", c_rdata, 64'h0000_0000_0000_8001);
    txn(0, 0, 3'b010, 64'h8000_0004, 64'd0, 5'd12, 0);
    check("lw_rdata", c_rdata, 64'hFFFF_FFFF_8001_2345);
    txn(0, 0, 3'b110, 64'h8000_0004, 64'd0, 5'd12, 0);
    check("lwu_rdata", c_rdata, 64'h0000_0000_8001_2345);
    txn(0, 0, 3'b011, 64'h8000_0000, 64'd0, 5'd13, 0);
    check("ld_rdata", c_rdata, 64'h8001_2345_6789_ABCD);

    // Faults
    txn(0, 0, 3'b010, 64'h8000_0002, 64'd0, 5'd14, 0);
    check("lw_mis_lat", lat, 1);
    check("lw_mis_strobes", n_ren + n_wen, 0);
    check("lw_mis_flags", 64'({c_st, c_mis, c_ill}), 64'b010);
    check("lw_mis_rd", 64'(c_rd), 64'd14);
    check("lw_mis_rdata", c_rdata, 64'd0);
    txn(0, 0, 3'b111, 64'h8000_0001, 64'd0, 5'd15, 0);
    check("l111_flags", 64'({c_st, c_mis, c_ill}), 64'b001);
    check("l111_strobes", n_ren + n_wen, 0);
    txn(0, 1, 3'b100, 64'h8000_0000, 64'hFF, 5'd16, 0);
    check("s100_flags", 64'({c_st, c_mis, c_ill}), 64'b101);
    check("s100_strobes", n_ren + n_wen, 0);
    txn(0, 1, 3'b011, 64'h8000_0004, 64'hFF, 5'd17, 0);
    check("sd_mis_flags", 64'({c_st, c_mis, c_ill}), 64'b110);
    check("sd_mis_wen", n_wen, 0);

    // LOAD_LATENCY=3 instance
    rd_val = 64'h0000_8000_0000_0000;
    txn(1, 0, 3'b000, 64'h8000_0005, 64'd0, 5'd18, 2);
    check("l3_lb_lat", lat, 5);
    check("l3_lb_rdata", c_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    check("l3_lb_ren", n_ren, 1);
    t_sel = 1'b0;
    #1;

    // Reset while a load sits in WAIT
    rd_val = 64'h0123_4567_89AB_CDEF;
    t_store = 1'b0; t_f3 = 3'b011; t_addr = 64'h8000_0010; t_rd = 5'd19; t_valid = 1'b1;
    @(posedge clk);
    #1 t_valid = 1'b0;
    @(negedge clk);
    check("rstmid_access_ren", 64'(bus1.data_r_en), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_strobes", 64'({bus1.data_r_en, bus1.data_w_en, bus1.req_ready}), 64'd0);
    check("rstmid_resp", 64'({bus1.resp_valid, bus1.resp_rd}), 64'd0);
    check("rstmid_rdata", bus1.resp_rdata, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstmid_quiet", 64'({bus1.data_r_en, bus1.data_w_en, bus1.resp_valid}), 64'd0);
    end
    txn(0, 1, 3'b011, 64'h8000_0018, 64'hA5A5_5A5A_0F0F_F0F0, 5'd20, 0);
    check("rstmid_sd_lat", lat, 2);
    check("rstmid_sd_w", c_w, 64'hA5A5_5A5A_0F0F_F0F0);
    check("rstmid_sd_rdata", c_rdata, 64'd0);
    check("rstmid_sd_rd", 64'(c_rd), 64'd20);
    check("rstmid_sd_ren", n_ren, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
